// File: rtl/adrv9001_rx_link_ctrl.sv
// ADRV9001 receive link bring-up controller.
// Sequences the serdes reset, qualifies valid_in spacing to declare lock,
// retries on timeout, and gates the sample stream so it flows only while locked.
`timescale 1ns/1ps
module adrv9001_rx_link_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_COUNT   = 64,
    parameter int VALID_PERIOD = 2,
    parameter int TIMEOUT      = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic        valid_in,
    input  logic [31:0] tdata_in,
    output logic        serdes_rst,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        locked,
    output logic        error,
    output logic [3:0]  retry_count,
    output logic [7:0]  loss_count
);

    localparam int              CW        = 16;
    localparam logic [3:0]      VP        = 4'(VALID_PERIOD);
    localparam logic [CW-1:0]   RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]   TMO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   LOCK_N    = CW'(LOCK_COUNT);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_WAIT_LOCK, S_LOCKED, S_FAIL
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_rst_cnt;
    logic [CW-1:0] r_tmo_cnt;
    logic [CW-1:0] r_cons_cnt;
    logic [3:0]    r_gap;
    logic [3:0]    r_retry;
    logic [7:0]    r_loss;
    logic          r_serdes_rst;
    logic          r_locked;
    logic          r_error;
    logic          r_tvalid;
    logic [31:0]   r_tdata;

    state_t        w_state_next;
    logic [CW-1:0] w_rst_cnt_next;
    logic [CW-1:0] w_tmo_cnt_next;
    logic [CW-1:0] w_cons_cnt_next;
    logic [3:0]    w_gap_next;
    logic [3:0]    w_retry_next;
    logic [7:0]    w_loss_next;
    logic [3:0]    w_gap_inc;
    logic          w_loss_event;
    logic          w_fwd;

    // Next-state and counter updates; enable low overrides everything.
    always_comb begin
        w_state_next    = r_state;
        w_rst_cnt_next  = r_rst_cnt;
        w_tmo_cnt_next  = r_tmo_cnt;
        w_cons_cnt_next = r_cons_cnt;
        w_gap_next      = r_gap;
        w_retry_next    = r_retry;
        w_loss_next     = r_loss;
        w_gap_inc       = (r_gap == 4'd15) ? 4'd15 : r_gap + 4'd1;
        // A pulse at the wrong spacing, or a silence longer than the period.
        w_loss_event    = (valid_in && (r_gap != VP)) || (!valid_in && (r_gap > VP));

        case (r_state)
            S_IDLE: begin
                w_rst_cnt_next  = '0;
                w_tmo_cnt_next  = '0;
                w_cons_cnt_next = '0;
                w_gap_next      = '0;
                if (enable) begin
                    w_state_next = S_RESET;
                    w_retry_next = '0;
                end
            end
            S_RESET: begin
                w_tmo_cnt_next  = '0;
                w_cons_cnt_next = '0;
                w_gap_next      = '0;
                if (r_rst_cnt == RST_LAST) begin
                    w_state_next   = S_WAIT_LOCK;
                    w_rst_cnt_next = '0;
                end else begin
                    w_rst_cnt_next = r_rst_cnt + CW'(1);
                end
            end
            S_WAIT_LOCK: begin
                w_gap_next     = valid_in ? 4'd1 : w_gap_inc;
                w_tmo_cnt_next = r_tmo_cnt + CW'(1);
                if (valid_in) begin
                    // The first pulse of an attempt has no reference, so it starts a run.
                    if ((r_cons_cnt != '0) && (r_gap == VP)) begin
                        w_cons_cnt_next = r_cons_cnt + CW'(1);
                    end else begin
                        w_cons_cnt_next = CW'(1);
                    end
                end else if (r_gap > VP) begin
                    w_cons_cnt_next = '0;
                end
                // Lock completion takes precedence over a coincident timeout.
                if (w_cons_cnt_next == LOCK_N) begin
                    w_state_next = S_LOCKED;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    if (r_retry < RETRY_MAX) begin
                        w_retry_next = r_retry + 4'd1;
                        w_state_next = S_RESET;
                    end else begin
                        w_state_next = S_FAIL;
                    end
                end
            end
            S_LOCKED: begin
                w_gap_next = valid_in ? 4'd1 : w_gap_inc;
                if (w_loss_event) begin
                    w_state_next    = S_RESET;
                    w_retry_next    = '0;
                    w_cons_cnt_next = '0;
                    w_loss_next     = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                end
            end
            S_FAIL: begin
                w_state_next = S_FAIL;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (!enable) begin
            w_state_next    = S_IDLE;
            w_rst_cnt_next  = '0;
            w_tmo_cnt_next  = '0;
            w_cons_cnt_next = '0;
            w_gap_next      = '0;
            w_retry_next    = r_retry;
            w_loss_next     = r_loss;
        end
    end

    // Forward only while staying in LOCKED, so an offending sample is dropped.
    assign w_fwd = (r_state == S_LOCKED) && (w_state_next == S_LOCKED);

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_rst_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_cons_cnt   <= '0;
            r_gap        <= '0;
            r_retry      <= '0;
            r_loss       <= '0;
            r_serdes_rst <= 1'b1;
            r_locked     <= 1'b0;
            r_error      <= 1'b0;
            r_tvalid     <= 1'b0;
            r_tdata      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_rst_cnt    <= w_rst_cnt_next;
            r_tmo_cnt    <= w_tmo_cnt_next;
            r_cons_cnt   <= w_cons_cnt_next;
            r_gap        <= w_gap_next;
            r_retry      <= w_retry_next;
            r_loss       <= w_loss_next;
            r_serdes_rst <= (w_state_next == S_IDLE) || (w_state_next == S_RESET) ||
                            (w_state_next == S_FAIL);
            r_locked     <= (w_state_next == S_LOCKED);
            r_error      <= (w_state_next == S_FAIL);
            r_tvalid     <= w_fwd && valid_in;
            if (w_fwd && valid_in) begin
                r_tdata <= tdata_in;
            end
        end
    end

    assign serdes_rst    = r_serdes_rst;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign locked        = r_locked;
    assign error         = r_error;
    assign retry_count   = r_retry;
    assign loss_count    = r_loss;

endmodule

// File: tb/tb_adrv9001_rx_link_ctrl.sv
// Directed bench for adrv9001_rx_link_ctrl: bring-up, glitch, timeout/fail,
// loss-of-lock, enable drop, mid-run reset and loss counter saturation.
`timescale 1ns/1ps
module tb_adrv9001_rx_link_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_COUNT   = 8;
    localparam int VALID_PERIOD = 2;
    localparam int TIMEOUT      = 64;
    localparam int MAX_RETRY    = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        valid_in;
    logic [31:0] tdata_in;
    logic        serdes_rst;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        locked;
    logic        error;
    logic [3:0]  retry_count;
    logic [7:0]  loss_count;

    int          checks   = 0;
    int          failures = 0;
    int          txn      = 0;
    logic [31:0] sb[$];
    logic [31:0] last_fwd = '0;

    always #5 clk = ~clk;

    adrv9001_rx_link_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_COUNT   (LOCK_COUNT),
        .VALID_PERIOD (VALID_PERIOD),
        .TIMEOUT      (TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .valid_in      (valid_in),
        .tdata_in      (tdata_in),
        .serdes_rst    (serdes_rst),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .locked        (locked),
        .error         (error),
        .retry_count   (retry_count),
        .loss_count    (loss_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // One clock of stimulus; fwd marks a sample expected on m_axis.
    task automatic cyc(input logic v, input logic fwd);
        valid_in = v;
        tdata_in = $urandom;
        if (fwd) begin
            sb.push_back(tdata_in);
            last_fwd = tdata_in;
        end
        @(posedge clk);
        #1;
    endtask

    // Called after the edge entering RESET: three more high cycles, then low.
    task automatic rst_phase(input string tag);
        for (int i = 0; i < RST_CYCLES - 1; i++) begin
            cyc(1'b0, 1'b0);
            chk1({tag, "_serdes_rst_hi"}, serdes_rst, 1'b1);
        end
        cyc(1'b0, 1'b0);
        chk1({tag, "_serdes_rst_lo"}, serdes_rst, 1'b0);
    endtask

    // Eight correctly spaced pulses; lock must appear right after the eighth.
    task automatic lock_pulses(input string tag);
        for (int i = 1; i <= LOCK_COUNT; i++) begin
            cyc(1'b1, 1'b0);
            if (i >= LOCK_COUNT - 1) chk1({tag, "_locked"}, locked, (i == LOCK_COUNT));
            cyc(1'b0, 1'b0);
        end
    endtask

    // Scoreboard monitor: every forwarded beat must match the oldest expected sample.
    always @(negedge clk) begin
        if (rstn === 1'b1 && m_axis_tvalid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL axis_unexpected observed=0x%0h expected=none", m_axis_tdata);
            end
            if (sb.size() != 0) begin
                logic [31:0] exp_d;
                exp_d = sb.pop_front();
                txn++;
                $display("txn %0d m_axis_tdata=0x%08h", txn, m_axis_tdata);
                chk("axis_tdata", m_axis_tdata, exp_d);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn     = 1'b0;
        enable   = 1'b0;
        valid_in = 1'b0;
        tdata_in = '0;
        repeat (2) @(posedge clk);
        #1;
        $display("step reset values");
        chk1("rst_serdes_rst", serdes_rst, 1'b1);
        chk1("rst_locked", locked, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk1("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata", m_axis_tdata, 32'h0);
        chk("rst_retry", 32'(retry_count), 32'd0);
        chk("rst_loss", 32'(loss_count), 32'd0);
        rstn = 1'b1;
        cyc(1'b0, 1'b0);
        chk1("idle_serdes_rst", serdes_rst, 1'b1);

        $display("step bring-up");
        enable = 1'b1;
        cyc(1'b0, 1'b0);
        chk1("up_enter_rst", serdes_rst, 1'b1);
        chk("up_retry", 32'(retry_count), 32'd0);
        rst_phase("up");
        lock_pulses("up");
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b0, 1'b0);
        end
        chk1("up_tvalid_idle", m_axis_tvalid, 1'b0);
        chk("up_sb_drained", 32'(sb.size()), 32'd0);

        $display("step loss in LOCKED");
        cyc(1'b0, 1'b0);
        chk1("loss_still_locked", locked, 1'b1);
        cyc(1'b0, 1'b0);
        chk1("loss_locked", locked, 1'b0);
        chk("loss_count1", 32'(loss_count), 32'd1);
        chk1("loss_tvalid", m_axis_tvalid, 1'b0);
        chk1("loss_serdes_rst", serdes_rst, 1'b1);
        chk("loss_tdata_hold", m_axis_tdata, last_fwd);
        rst_phase("loss");
        lock_pulses("relock");
        chk("relock_retry", 32'(retry_count), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b0, 1'b0);
        end

        $display("step enable drop in LOCKED");
        enable = 1'b0;
        cyc(1'b0, 1'b0);
        chk1("endrop_locked", locked, 1'b0);
        chk1("endrop_serdes_rst", serdes_rst, 1'b1);
        chk1("endrop_error", error, 1'b0);
        chk1("endrop_tvalid", m_axis_tvalid, 1'b0);

        $display("step spacing glitch before lock");
        enable = 1'b1;
        cyc(1'b0, 1'b0);
        rst_phase("gl");
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk1("gl_glitch_locked", locked, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 1; i <= LOCK_COUNT - 1; i++) begin
            cyc(1'b1, 1'b0);
            chk1("gl_locked", locked, (i == LOCK_COUNT - 1));
            cyc(1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1);
            cyc(1'b0, 1'b0);
        end
        enable = 1'b0;
        cyc(1'b0, 1'b0);

        $display("step timeout and retries");
        enable = 1'b1;
        cyc(1'b0, 1'b0);
        chk("to_retry_start", 32'(retry_count), 32'd0);
        rst_phase("to0");
        for (int a = 0; a <= MAX_RETRY; a++) begin
            for (int c = 0; c < TIMEOUT - 1; c++) cyc(1'b0, 1'b0);
            chk1("to_wait_serdes_rst", serdes_rst, 1'b0);
            chk("to_wait_retry", 32'(retry_count), 32'(a));
            cyc(1'b0, 1'b0);
            if (a < MAX_RETRY) begin
                chk1("to_retry_serdes_rst", serdes_rst, 1'b1);
                chk("to_retry_count", 32'(retry_count), 32'(a + 1));
                chk1("to_retry_error", error, 1'b0);
                rst_phase("to");
            end else begin
                chk1("to_fail_error", error, 1'b1);
                chk1("to_fail_serdes_rst", serdes_rst, 1'b1);
                chk("to_fail_retry", 32'(retry_count), 32'(MAX_RETRY));
                chk1("to_fail_locked", locked, 1'b0);
            end
        end
        repeat (5) cyc(1'b1, 1'b0);
        chk1("fail_hold_error", error, 1'b1);
        enable = 1'b0;
        cyc(1'b0, 1'b0);
        chk1("fail_exit_error", error, 1'b0);
        chk1("fail_exit_serdes_rst", serdes_rst, 1'b1);

        $display("step reset during WAIT_LOCK");
        enable = 1'b1;
        cyc(1'b0, 1'b0);
        rst_phase("mr");
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        rstn = 1'b0;
        cyc(1'b0, 1'b0);
        chk1("mr_serdes_rst", serdes_rst, 1'b1);
        chk1("mr_locked", locked, 1'b0);
        chk1("mr_error", error, 1'b0);
        chk1("mr_tvalid", m_axis_tvalid, 1'b0);
        chk("mr_tdata", m_axis_tdata, 32'h0);
        chk("mr_retry", 32'(retry_count), 32'd0);
        chk("mr_loss", 32'(loss_count), 32'd0);
        rstn = 1'b1;

        $display("step loss counter saturation");
        cyc(1'b0, 1'b0);
        rst_phase("sat0");
        for (int n = 1; n <= 256; n++) begin
            for (int i = 0; i < LOCK_COUNT; i++) begin
                cyc(1'b1, 1'b0);
                cyc(1'b0, 1'b0);
            end
            cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
            chk("sat_loss_count", 32'(loss_count), (n > 255) ? 32'd255 : 32'(n));
            chk1("sat_tvalid", m_axis_tvalid, 1'b0);
            rst_phase("sat");
        end

        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adrv9001_rx_link_ctrl.md
ADRV9001_RX_LINK_CTRL -- requirements
Module: adrv9001_rx_link_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles serdes_rst is held in the RESET state.
REQ-002 SHALL have parameter LOCK_COUNT, default 64: consecutive correctly spaced valid pulses required to declare lock.
REQ-003 SHALL have parameter VALID_PERIOD, default 2: expected cycles between valid_in pulses (range 1..15).
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum cycles in WAIT_LOCK per attempt.
REQ-005 SHALL have parameter MAX_RETRY, default 3: lock attempts allowed after the first before FAIL.
REQ-006 SHALL have port clk, input, 1: divided data clock; all logic runs on its rising edge.
REQ-007 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port enable, input, 1: level request to bring up the receive link.
REQ-009 SHALL have port valid_in, input, 1: aligned-sample valid from the receive aligner.
REQ-010 SHALL have port tdata_in, input, 32: aligned {I,Q} sample.
REQ-011 SHALL have port serdes_rst, output, 1: active-high reset to the serdes/pack/align path.
REQ-012 SHALL have port m_axis_tdata, output, 32: gated sample output.
REQ-013 SHALL have port m_axis_tvalid, output, 1: gated valid output.
REQ-014 SHALL have port locked, output, 1: high only in the LOCKED state.
REQ-015 SHALL have port error, output, 1: high only in the FAIL state.
REQ-016 SHALL have port retry_count, output, 4: attempts used in the current bring-up.
REQ-017 SHALL have port loss_count, output, 8: lock losses since reset, saturating at 255.

Function
REQ-018 SHALL implement five states: IDLE, RESET, WAIT_LOCK, LOCKED, FAIL; all outputs are registered.
REQ-019 When enable=0 in any state, the FSM SHALL enter IDLE on the next cycle; this event has highest priority.
REQ-020 IDLE: serdes_rst=1; enable=1 -> RESET, retry_count cleared to 0.
REQ-021 RESET: serdes_rst=1 for exactly RST_CYCLES cycles, then -> WAIT_LOCK; lock and timeout counters cleared.
REQ-022 WAIT_LOCK: serdes_rst=0; gap counter counts cycles since the last valid_in and saturates at 15.
REQ-023 WAIT_LOCK, first valid_in of the attempt: consecutive count = 1.
REQ-024 WAIT_LOCK, later valid_in with gap == VALID_PERIOD: consecutive count +1.
REQ-025 WAIT_LOCK, valid_in with gap != VALID_PERIOD: consecutive count = 1.
REQ-026 WAIT_LOCK, gap exceeding VALID_PERIOD with no valid_in: consecutive count = 0.
REQ-027 WAIT_LOCK: the cycle in which consecutive count reaches LOCK_COUNT -> LOCKED on the next edge.
REQ-028 WAIT_LOCK timeout: TIMEOUT cycles elapsed without lock and retry_count < MAX_RETRY -> retry_count +1, -> RESET.
REQ-029 WAIT_LOCK timeout with retry_count == MAX_RETRY -> FAIL.
REQ-030 If lock completion and timeout occur in the same cycle, lock SHALL win.
REQ-031 LOCKED: locked=1, serdes_rst=0; m_axis_tdata/m_axis_tvalid register tdata_in/valid_in with 1-cycle latency.
REQ-032 Outside LOCKED, m_axis_tvalid SHALL be 0; m_axis_tdata holds its last value.
REQ-033 LOCKED loss-of-lock: valid_in with gap != VALID_PERIOD, or gap > VALID_PERIOD -> loss_count +1 (saturating), retry_count = 0, -> RESET.
REQ-034 On loss-of-lock, the offending sample SHALL NOT be forwarded, so m_axis_tvalid is 0 on the following cycle.
REQ-035 FAIL: error=1, serdes_rst=1; exits only through enable=0 -> IDLE.

Reset
REQ-036 rstn=0 sampled on a rising edge SHALL force state IDLE, serdes_rst=1, and locked, error, m_axis_tvalid=0.
REQ-037 rstn=0 SHALL also clear m_axis_tdata, retry_count, loss_count and all internal counters to 0.
REQ-038 Reset asserted mid-operation (any state) SHALL take effect on that edge with no partial output.

Verification (RST_CYCLES=4, LOCK_COUNT=8, VALID_PERIOD=2, TIMEOUT=64, MAX_RETRY=2)
REQ-039 Bring-up: enable=1, valid_in every 2nd cycle -> serdes_rst high 4 cycles; locked rises 1 cycle after the 8th pulse; m_axis_tdata equals tdata_in delayed 1 cycle.
REQ-040 Spacing glitch before lock: 5 good pulses, one at gap 3, then good pulses -> lock only after 8 consecutive good pulses counted from the glitched pulse as 1.
REQ-041 No valid_in, enable=1 -> 3 attempts (retry_count 0,1,2), each ending at 64 cycles; then error=1, serdes_rst=1; enable=0 -> IDLE, error=0.
REQ-042 Loss in LOCKED: one missing pulse -> locked=0 next cycle, loss_count=1, m_axis_tvalid=0, serdes_rst high 4 cycles, relock with retry_count=0.
REQ-043 enable=0 during LOCKED, then rstn=0 during WAIT_LOCK -> IDLE next cycle each time; all outputs at reset values; loss_count 255 plus one more loss stays 255.
